// File: rtl/iecdrv_trackmem_arb.sv
// Track buffer port arbiter: drive side has priority, host side gets a starvation guard.
// Issues registered RAM commands and routes read data back to the owning requester.
module iecdrv_trackmem_arb #(
   parameter int unsigned ADDRWIDTH = 13,
   parameter int unsigned RD_LAT    = 2,
   parameter int unsigned MAXBURST  = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 drv_req,
   input  logic                 drv_we,
   input  logic [ADDRWIDTH-1:0] drv_addr,
   input  logic [7:0]           drv_din,
   output logic                 drv_ack,
   output logic [7:0]           drv_dout,
   output logic                 drv_valid,
   input  logic                 host_req,
   input  logic                 host_we,
   input  logic [ADDRWIDTH-1:0] host_addr,
   input  logic [7:0]           host_din,
   output logic                 host_ack,
   output logic [7:0]           host_dout,
   output logic                 host_valid,
   output logic [ADDRWIDTH-1:0] mem_addr,
   output logic [7:0]           mem_din,
   output logic                 mem_wren,
   input  logic [7:0]           mem_q,
   output logic                 dirty,
   input  logic                 dirty_clr
);

   localparam int unsigned BurstW = $clog2(MAXBURST + 1);

   logic [BurstW-1:0]    burst_q, burst_d;
   logic [ADDRWIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [7:0]           mem_din_q, mem_din_d;
   logic                 mem_wren_q, mem_wren_d;
   logic [RD_LAT:0]      tag_vld_q, tag_vld_d;
   logic [RD_LAT:0]      tag_own_q, tag_own_d;
   logic [7:0]           drv_dout_q, drv_dout_d, host_dout_q, host_dout_d;
   logic                 drv_valid_q, drv_valid_d, host_valid_q, host_valid_d;
   logic                 drv_wr_q, drv_wr_d;
   logic                 dirty_q, dirty_d;
   logic                 force_host, rd_grant;

   always_comb begin
      force_host = host_req & (burst_q == BurstW'(MAXBURST));
      drv_ack    = reset_n & drv_req & ~force_host;
      host_ack   = reset_n & host_req & ~drv_ack;
      rd_grant   = (drv_ack & ~drv_we) | (host_ack & ~host_we);
   end

   always_comb begin
      burst_d = burst_q;
      if (host_ack || !host_req) begin
         burst_d = '0;
      end else if (drv_ack && (burst_q != BurstW'(MAXBURST))) begin
         burst_d = burst_q + 1'b1;
      end
   end

   always_comb begin
      mem_addr_d = mem_addr_q;
      mem_din_d  = mem_din_q;
      mem_wren_d = 1'b0;
      if (drv_ack) begin
         mem_addr_d = drv_addr;
         mem_din_d  = drv_din;
         mem_wren_d = drv_we;
      end else if (host_ack) begin
         mem_addr_d = host_addr;
         mem_din_d  = host_din;
         mem_wren_d = host_we;
      end
   end

   // Tag slot RD_LAT lines up with the cycle mem_q carries that read's data.
   always_comb begin
      tag_vld_d    = {tag_vld_q[RD_LAT-1:0], rd_grant};
      tag_own_d    = {tag_own_q[RD_LAT-1:0], host_ack};
      drv_valid_d  = tag_vld_q[RD_LAT] & ~tag_own_q[RD_LAT];
      host_valid_d = tag_vld_q[RD_LAT] & tag_own_q[RD_LAT];
      drv_dout_d   = drv_valid_d ? mem_q : drv_dout_q;
      host_dout_d  = host_valid_d ? mem_q : host_dout_q;
   end

   // Set is delayed one cycle so it lands on the same edge as a clear issued right after it.
   always_comb begin
      drv_wr_d = drv_ack & drv_we;
      dirty_d  = drv_wr_q | (dirty_q & ~dirty_clr);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         burst_q      <= '0;
         mem_addr_q   <= '0;
         mem_din_q    <= '0;
         mem_wren_q   <= 1'b0;
         tag_vld_q    <= '0;
         tag_own_q    <= '0;
         drv_dout_q   <= '0;
         host_dout_q  <= '0;
         drv_valid_q  <= 1'b0;
         host_valid_q <= 1'b0;
         drv_wr_q     <= 1'b0;
         dirty_q      <= 1'b0;
      end else begin
         burst_q      <= burst_d;
         mem_addr_q   <= mem_addr_d;
         mem_din_q    <= mem_din_d;
         mem_wren_q   <= mem_wren_d;
         tag_vld_q    <= tag_vld_d;
         tag_own_q    <= tag_own_d;
         drv_dout_q   <= drv_dout_d;
         host_dout_q  <= host_dout_d;
         drv_valid_q  <= drv_valid_d;
         host_valid_q <= host_valid_d;
         drv_wr_q     <= drv_wr_d;
         dirty_q      <= dirty_d;
      end
   end

   assign mem_addr   = mem_addr_q;
   assign mem_din    = mem_din_q;
   assign mem_wren   = mem_wren_q;
   assign drv_dout   = drv_dout_q;
   assign drv_valid  = drv_valid_q;
   assign host_dout  = host_dout_q;
   assign host_valid = host_valid_q;
   assign dirty      = dirty_q;

endmodule

// File: tb/tb_iecdrv_trackmem_arb.sv
// Bench for iecdrv_trackmem_arb: behavioural RAM, transaction-level reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_iecdrv_trackmem_arb;

   localparam int unsigned AW       = 13;
   localparam int unsigned RD_LAT   = 2;
   localparam int unsigned MAXBURST = 4;

   logic          clk, reset_n;
   logic          drv_req, drv_we, drv_ack, drv_valid;
   logic [AW-1:0] drv_addr;
   logic [7:0]    drv_din, drv_dout;
   logic          host_req, host_we, host_ack, host_valid;
   logic [AW-1:0] host_addr;
   logic [7:0]    host_din, host_dout;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_din, mem_q;
   logic          mem_wren, dirty, dirty_clr;

   int nchk = 0;
   int nerr = 0;

   iecdrv_trackmem_arb #(
      .ADDRWIDTH(AW), .RD_LAT(RD_LAT), .MAXBURST(MAXBURST)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .drv_req(drv_req), .drv_we(drv_we), .drv_addr(drv_addr), .drv_din(drv_din),
      .drv_ack(drv_ack), .drv_dout(drv_dout), .drv_valid(drv_valid),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_din(host_din),
      .host_ack(host_ack), .host_dout(host_dout), .host_valid(host_valid),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_wren(mem_wren), .mem_q(mem_q),
      .dirty(dirty), .dirty_clr(dirty_clr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // RAM with registered address and registered output (two-cycle read).
   logic [7:0]    ram [1 << AW];
   logic [AW-1:0] ram_a_q;
   initial begin
      for (int i = 0; i < (1 << AW); i++) ram[i] = 8'h00;
      ram_a_q = '0;
      mem_q   = 8'h00;
   end
   always @(posedge clk) begin
      ram_a_q <= mem_addr;
      mem_q   <= ram[ram_a_q];
      if (mem_wren) ram[mem_addr] <= mem_din;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: track contents, outstanding reads with their due cycle, expected outputs.
   typedef struct {
      int         due;
      bit         host;
      logic [7:0] data;
   } ret_t;

   ret_t          rq[$];
   logic [7:0]    arr [1 << AW];
   int            cyc = 0;
   int            m_burst = 0;
   logic [AW-1:0] m_addr = '0;
   logic [7:0]    m_din = '0, m_ddout = '0, m_hdout = '0;
   logic          m_wren = 0, m_dv = 0, m_hv = 0, m_dirty = 0, m_dwr = 0;

   initial for (int i = 0; i < (1 << AW); i++) arr[i] = 8'h00;

   function automatic logic m_dack();
      return drv_req && !(host_req && (m_burst == MAXBURST));
   endfunction

   always @(posedge clk) begin
      logic da, ha;
      ret_t r;
      if (!reset_n) begin
         m_burst = 0; m_addr = '0; m_din = '0; m_wren = 0;
         m_dv = 0; m_hv = 0; m_ddout = '0; m_hdout = '0;
         m_dirty = 0; m_dwr = 0;
         rq.delete();
      end else begin
         da = m_dack();
         ha = host_req && !da;
         m_dv = 0;
         m_hv = 0;
         if (rq.size() > 0 && rq[0].due == cyc + 1) begin
            r = rq.pop_front();
            if (r.host) begin m_hv = 1; m_hdout = r.data; end
            else begin m_dv = 1; m_ddout = r.data; end
         end
         m_wren = 0;
         if (da) begin
            m_addr = drv_addr; m_din = drv_din; m_wren = drv_we;
            if (!drv_we) rq.push_back('{cyc + 2 + RD_LAT, 1'b0, arr[drv_addr]});
            else arr[drv_addr] = drv_din;
         end else if (ha) begin
            m_addr = host_addr; m_din = host_din; m_wren = host_we;
            if (!host_we) rq.push_back('{cyc + 2 + RD_LAT, 1'b1, arr[host_addr]});
            else arr[host_addr] = host_din;
         end
         m_dirty = m_dwr ? 1'b1 : (dirty_clr ? 1'b0 : m_dirty);
         m_dwr = da && drv_we;
         if (ha || !host_req) m_burst = 0;
         else if (da && m_burst < MAXBURST) m_burst++;
      end
      cyc++;
   end

   always @(negedge clk) begin
      if (!reset_n) begin
         chk("rst_acks", {drv_ack, host_ack}, 0);
         chk("rst_mem", {mem_wren, mem_din, 3'b0, mem_addr}, 0);
         chk("rst_ret", {drv_valid, host_valid, drv_dout, host_dout, dirty}, 0);
      end else begin
         chk("drv_ack", drv_ack, m_dack());
         chk("host_ack", host_ack, host_req && !m_dack());
         chk("mem_addr", mem_addr, m_addr);
         chk("mem_din", mem_din, m_din);
         chk("mem_wren", mem_wren, m_wren);
         chk("drv_valid", drv_valid, m_dv);
         chk("drv_dout", drv_dout, m_ddout);
         chk("host_valid", host_valid, m_hv);
         chk("host_dout", host_dout, m_hdout);
         chk("dirty", dirty, m_dirty);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      drv_req = 0; host_req = 0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic host_wr(input logic [AW-1:0] a, input logic [7:0] d);
      host_req = 1; host_we = 1; host_addr = a; host_din = d;
      tick();
      host_req = 0;
   endtask

   initial begin
      string      seq;
      logic [7:0] hret[$];
      int         dp, hp;

      reset_n = 0; dirty_clr = 0;
      drv_req = 1; drv_we = 0; drv_addr = '0; drv_din = '0;
      host_req = 1; host_we = 0; host_addr = '0; host_din = '0;

      // Reset held with both requests pending.
      tick(); tick();
      #2;
      chk("lit_rst_drv_ack", drv_ack, 0);
      chk("lit_rst_host_ack", host_ack, 0);
      chk("lit_rst_valid", drv_valid, 0);
      tick();
      reset_n = 1;
      #2;
      chk("lit_release_drv_ack", drv_ack, 1);
      chk("lit_release_host_ack", host_ack, 0);
      tick();
      idle(6);

      // Drive read latency and host-write-does-not-dirty.
      host_wr(13'h0123, 8'hA5);
      idle(2);
      chk("lit_host_wr_no_dirty", dirty, 0);
      drv_req = 1; drv_we = 0; drv_addr = 13'h0123;
      #2;
      chk("lit_lat_ack", drv_ack, 1);
      tick();
      drv_req = 0;
      #2;
      chk("lit_lat_mem_addr", mem_addr, 13'h0123);
      chk("lit_lat_mem_wren", mem_wren, 0);
      for (int k = 2; k <= 5; k++) begin
         tick();
         #2;
         chk("lit_lat_valid", drv_valid, (k == 4) ? 1 : 0);
         chk("lit_lat_host_valid", host_valid, 0);
         if (k == 4) chk("lit_lat_dout", drv_dout, 8'hA5);
      end
      idle(2);

      // Contention with both requesters held.
      for (int i = 0; i < 10; i++) host_wr(AW'(32'h40 + i), 8'(32'h80 + i));
      idle(2);
      seq = ""; dp = 0; hp = 0;
      for (int i = 0; i < 10; i++) begin
         drv_req = 1; drv_we = 0; drv_addr = AW'(32'h40 + dp);
         host_req = 1; host_we = 0; host_addr = AW'(32'h40 + hp);
         #2;
         if (drv_ack) begin seq = {seq, "D"}; dp++; end
         else if (host_ack) begin seq = {seq, "H"}; hp++; end
         if (host_valid) hret.push_back(host_dout);
         tick();
      end
      drv_req = 0; host_req = 0;
      for (int i = 0; i < 6; i++) begin
         #2;
         if (host_valid) hret.push_back(host_dout);
         tick();
      end
      nchk++;
      if (seq != "DDDDHDDDDH") begin
         nerr++;
         $display("FAIL lit_ack_seq: got %s expected DDDDHDDDDH", seq);
      end
      chk("lit_host_ret_cnt", hret.size(), 2);
      if (hret.size() == 2) begin
         chk("lit_host_ret0", hret[0], 8'h80);
         chk("lit_host_ret1", hret[1], 8'h81);
      end

      // Interleaved drive/host reads.
      host_wr(13'h0010, 8'h11);
      host_wr(13'h0020, 8'h22);
      idle(1);
      seq = "";
      for (int i = 0; i < 10; i++) begin
         drv_req = (i < 4) && (i % 2 == 0);
         host_req = (i < 4) && (i % 2 == 1);
         drv_we = 0; host_we = 0;
         drv_addr = 13'h0010; host_addr = 13'h0020;
         #2;
         if (drv_valid) begin seq = {seq, "d"}; chk("lit_il_drv", drv_dout, 8'h11); end
         if (host_valid) begin seq = {seq, "h"}; chk("lit_il_host", host_dout, 8'h22); end
         tick();
      end
      nchk++;
      if (seq != "dhdh") begin
         nerr++;
         $display("FAIL lit_il_order: got %s expected dhdh", seq);
      end
      idle(2);

      // Dirty: set coinciding with clear wins; clear alone clears; host write leaves it clear.
      drv_req = 1; drv_we = 1; drv_addr = 13'h0200; drv_din = 8'h5A;
      tick();
      drv_req = 0; dirty_clr = 1;
      tick();
      dirty_clr = 0;
      #2;
      chk("lit_dirty_set_wins", dirty, 1);
      idle(3);
      chk("lit_dirty_hold", dirty, 1);
      dirty_clr = 1;
      tick();
      dirty_clr = 0;
      #2;
      chk("lit_dirty_cleared", dirty, 0);
      host_wr(13'h0300, 8'h3C);
      idle(2);
      chk("lit_dirty_host_wr", dirty, 0);

      // Reset during an in-flight drive read.
      drv_req = 1; drv_we = 0; drv_addr = 13'h0300;
      tick();
      drv_req = 0;
      tick();
      reset_n = 0;
      tick();
      reset_n = 1;
      tick();
      #2;
      chk("lit_mid_rst_no_valid", drv_valid, 0);
      tick();
      #2;
      chk("lit_mid_rst_no_valid2", drv_valid, 0);
      idle(2);
      drv_req = 1; drv_we = 0; drv_addr = 13'h0300;
      tick();
      drv_req = 0;
      for (int k = 1; k <= 5; k++) begin
         #2;
         chk("lit_post_rst_valid", drv_valid, (k == 4) ? 1 : 0);
         if (k == 4) chk("lit_post_rst_dout", drv_dout, 8'h3C);
         tick();
      end
      idle(3);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
